// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/complete stage.
// Default lane counts plus the tag and result widths. TAG_W matches the ROB
// size (RobSize) and DATA_W matches the machine word (MemoryWord).
// wb_lane_t is one execute/memory result lane; cdb_port_t is one CDB port.
package wb_pkg;
    localparam int N_WB_DEF  = 4;
    localparam int N_CDB_DEF = 2;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              regwr;
        logic              rd_nz;
        logic              cjump;
        logic              pred;
        logic              taken;
    } wb_lane_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_port_t;
endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane pending-broadcast FIFO.
// Ports: clk, reset (async, active low), flush (sync clear), push/din,
// pop (caller guarantees non-empty), count (registered occupancy), head.
// DEPTH must be a power of two so the pointers wrap on their own.
module wb_lane_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign count = cnt_q;
    assign head  = mem_q[rptr_q];
endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback/complete stage between the result lanes and the
// ROB, map table and CDB.
// Inputs: per-lane result (wb_*), rob_head for age compare, flush_in.
// Outputs: registered ROB/map-table strobes (1-cycle latency), oldest
// mispredict pulse, N_CDB registered broadcast ports fed from per-lane
// FIFOs through a round-robin arbiter; wb_ready is per-lane backpressure.
// Optional: define WB_CDB_BYPASS_EN to let a result arriving at an empty
// lane FIFO win a CDB port in its arrival cycle.
module wb_commit_multi import wb_pkg::*; #(
    parameter int N_WB      = N_WB_DEF,
    parameter int N_CDB     = N_CDB_DEF,
    parameter int BUF_DEPTH = 4,
    parameter int DATA_W    = wb_pkg::DATA_W,
    parameter int TAG_W     = wb_pkg::TAG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_WB-1:0]         wb_valid,
    input  logic [N_WB*TAG_W-1:0]   wb_tag,
    input  logic [N_WB*DATA_W-1:0]  wb_data,
    input  logic [N_WB-1:0]         wb_regwr,
    input  logic [N_WB-1:0]         wb_rd_nz,
    input  logic [N_WB-1:0]         wb_cjump,
    input  logic [N_WB-1:0]         wb_pred,
    input  logic [N_WB-1:0]         wb_taken,
    output logic [N_WB-1:0]         wb_ready,
    input  logic [TAG_W-1:0]        rob_head,
    input  logic                    flush_in,
    output logic [N_WB-1:0]         rob_wr_valid,
    output logic [N_WB*TAG_W-1:0]   rob_wr_tag,
    output logic [N_WB*DATA_W-1:0]  rob_wr_value,
    output logic [N_WB-1:0]         rob_wr_value_en,
    output logic [N_WB-1:0]         rob_wr_flush,
    output logic [N_WB-1:0]         mt_wr_valid,
    output logic [N_WB*TAG_W-1:0]   mt_wr_tag,
    output logic                    mispredict_valid,
    output logic [TAG_W-1:0]        mispredict_tag,
    output logic [N_CDB-1:0]        cdb_valid,
    output logic [N_CDB*TAG_W-1:0]  cdb_tag,
    output logic [N_CDB*DATA_W-1:0] cdb_value
);
    localparam int FW    = TAG_W + DATA_W;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RR_W  = (N_WB > 1) ? $clog2(N_WB) : 1;

    logic [N_WB-1:0]            accept, push, pop, bypass, mp_flag;
    logic [N_WB-1:0][CNT_W-1:0] fifo_cnt;
    logic [N_WB-1:0][FW-1:0]    fifo_head, fifo_din;

    logic [RR_W-1:0]         rr_q, rr_d;
    logic [N_WB-1:0]         rob_wr_valid_q, rob_wr_valid_d, rob_wr_value_en_q, rob_wr_value_en_d;
    logic [N_WB-1:0]         rob_wr_flush_q, rob_wr_flush_d, mt_wr_valid_q, mt_wr_valid_d;
    logic [N_WB*TAG_W-1:0]   rob_wr_tag_q, rob_wr_tag_d, mt_wr_tag_q, mt_wr_tag_d;
    logic [N_WB*DATA_W-1:0]  rob_wr_value_q, rob_wr_value_d;
    logic                    mispredict_valid_q, mispredict_valid_d;
    logic [TAG_W-1:0]        mispredict_tag_q, mispredict_tag_d, mp_dist, mp_best;
    logic [N_CDB-1:0]        cdb_valid_q, cdb_valid_d;
    logic [N_CDB*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [N_CDB*DATA_W-1:0] cdb_value_q, cdb_value_d;

    for (genvar i = 0; i < N_WB; i++) begin : g_lane
        assign wb_ready[i] = (fifo_cnt[i] != CNT_W'(BUF_DEPTH));
        assign accept[i]   = wb_valid[i] & (wb_tag[i*TAG_W +: TAG_W] != '0) & wb_ready[i] & ~flush_in;
        assign mp_flag[i]  = accept[i] & wb_cjump[i] & (wb_pred[i] ^ wb_taken[i]);
        assign push[i]     = accept[i] & wb_regwr[i] & ~bypass[i];
        assign fifo_din[i] = {wb_tag[i*TAG_W +: TAG_W], wb_data[i*DATA_W +: DATA_W]};

        wb_lane_fifo #(.W(FW), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush_in),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (fifo_din[i]),
            .count (fifo_cnt[i]),
            .head  (fifo_head[i])
        );
    end

    // ROB / map-table strobes and oldest-mispredict select.
    always_comb begin
        rob_wr_valid_d     = accept;
        rob_wr_value_en_d  = accept & wb_regwr & ~wb_cjump;
        rob_wr_flush_d     = mp_flag;
        mt_wr_valid_d      = accept & wb_regwr & wb_rd_nz;
        rob_wr_tag_d       = '0;
        rob_wr_value_d     = '0;
        mt_wr_tag_d        = '0;
        mispredict_valid_d = 1'b0;
        mispredict_tag_d   = '0;
        mp_dist            = '0;
        mp_best            = '0;
        for (int i = 0; i < N_WB; i++) begin
            if (accept[i]) begin
                rob_wr_tag_d[i*TAG_W +: TAG_W]    = wb_tag[i*TAG_W +: TAG_W];
                rob_wr_value_d[i*DATA_W +: DATA_W] = wb_data[i*DATA_W +: DATA_W];
                mt_wr_tag_d[i*TAG_W +: TAG_W]     = wb_tag[i*TAG_W +: TAG_W];
            end
            // Age is the distance from the ROB head, wrapping at 2^TAG_W.
            mp_dist = wb_tag[i*TAG_W +: TAG_W] - rob_head;
            if (mp_flag[i] && (!mispredict_valid_d || mp_dist < mp_best)) begin
                mispredict_valid_d = 1'b1;
                mispredict_tag_d   = wb_tag[i*TAG_W +: TAG_W];
                mp_best            = mp_dist;
            end
        end
    end

    // Round-robin CDB arbitration over FIFO heads (and fresh results when
    // the bypass is built in).
    always_comb begin
        int   idx;
        int   n_grant;
        logic fifo_ne;
        logic byp_ok;
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        pop         = '0;
        bypass      = '0;
        rr_d        = rr_q;
        idx         = 0;
        n_grant     = 0;
        fifo_ne     = 1'b0;
        byp_ok      = 1'b0;
        if (flush_in) begin
            rr_d = '0;
        end else begin
            for (int k = 0; k < N_WB; k++) begin
                idx     = (int'(rr_q) + k) % N_WB;
                fifo_ne = (fifo_cnt[idx] != '0);
`ifdef WB_CDB_BYPASS_EN
                byp_ok  = accept[idx] & wb_regwr[idx] & ~fifo_ne;
`else
                byp_ok  = 1'b0;
`endif
                if ((fifo_ne || byp_ok) && n_grant < N_CDB) begin
                    cdb_valid_d[n_grant] = 1'b1;
                    if (fifo_ne) begin
                        cdb_tag_d[n_grant*TAG_W +: TAG_W]    = fifo_head[idx][FW-1 -: TAG_W];
                        cdb_value_d[n_grant*DATA_W +: DATA_W] = fifo_head[idx][DATA_W-1:0];
                        pop[idx] = 1'b1;
                    end else begin
                        cdb_tag_d[n_grant*TAG_W +: TAG_W]    = wb_tag[idx*TAG_W +: TAG_W];
                        cdb_value_d[n_grant*DATA_W +: DATA_W] = wb_data[idx*DATA_W +: DATA_W];
                        bypass[idx] = 1'b1;
                    end
                    n_grant = n_grant + 1;
                    rr_d    = RR_W'((idx + 1) % N_WB);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q               <= '0;
            rob_wr_valid_q     <= '0;
            rob_wr_tag_q       <= '0;
            rob_wr_value_q     <= '0;
            rob_wr_value_en_q  <= '0;
            rob_wr_flush_q     <= '0;
            mt_wr_valid_q      <= '0;
            mt_wr_tag_q        <= '0;
            mispredict_valid_q <= 1'b0;
            mispredict_tag_q   <= '0;
            cdb_valid_q        <= '0;
            cdb_tag_q          <= '0;
            cdb_value_q        <= '0;
        end else begin
            rr_q               <= rr_d;
            rob_wr_valid_q     <= rob_wr_valid_d;
            rob_wr_tag_q       <= rob_wr_tag_d;
            rob_wr_value_q     <= rob_wr_value_d;
            rob_wr_value_en_q  <= rob_wr_value_en_d;
            rob_wr_flush_q     <= rob_wr_flush_d;
            mt_wr_valid_q      <= mt_wr_valid_d;
            mt_wr_tag_q        <= mt_wr_tag_d;
            mispredict_valid_q <= mispredict_valid_d;
            mispredict_tag_q   <= mispredict_tag_d;
            cdb_valid_q        <= cdb_valid_d;
            cdb_tag_q          <= cdb_tag_d;
            cdb_value_q        <= cdb_value_d;
        end
    end

    assign rob_wr_valid     = rob_wr_valid_q;
    assign rob_wr_tag       = rob_wr_tag_q;
    assign rob_wr_value     = rob_wr_value_q;
    assign rob_wr_value_en  = rob_wr_value_en_q;
    assign rob_wr_flush     = rob_wr_flush_q;
    assign mt_wr_valid      = mt_wr_valid_q;
    assign mt_wr_tag        = mt_wr_tag_q;
    assign mispredict_valid = mispredict_valid_q;
    assign mispredict_tag   = mispredict_tag_q;
    assign cdb_valid        = cdb_valid_q;
    assign cdb_tag          = cdb_tag_q;
    assign cdb_value        = cdb_value_q;
endmodule

// File: tb/tb_wb_commit_multi.sv
// Bench for wb_commit_multi (N_WB=4, N_CDB=2, BUF_DEPTH=4, TAG_W=6, DATA_W=32).
// A queue-per-lane reference model predicts every output each cycle; a
// directed vector table and hand sequences cover the listed corner cases.
module tb_wb_commit_multi;
    localparam int NW = 4, NC = 2, DEPTH = 4, TW = 6, DW = 32;

    logic          clk = 1'b0, reset = 1'b0;
    logic [NW-1:0] wb_valid = '0, wb_regwr = '0, wb_rd_nz = '0, wb_cjump = '0, wb_pred = '0, wb_taken = '0;
    logic [NW*TW-1:0] wb_tag = '0;
    logic [NW*DW-1:0] wb_data = '0;
    logic [TW-1:0] rob_head = '0;
    logic          flush_in = 1'b0;
    logic [NW-1:0] wb_ready, rob_wr_valid, rob_wr_value_en, rob_wr_flush, mt_wr_valid;
    logic [NW*TW-1:0] rob_wr_tag, mt_wr_tag;
    logic [NW*DW-1:0] rob_wr_value;
    logic          mispredict_valid;
    logic [TW-1:0] mispredict_tag;
    logic [NC-1:0] cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_value;

    wb_commit_multi #(.N_WB(NW), .N_CDB(NC), .BUF_DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_regwr(wb_regwr), .wb_rd_nz(wb_rd_nz), .wb_cjump(wb_cjump), .wb_pred(wb_pred),
        .wb_taken(wb_taken), .wb_ready(wb_ready), .rob_head(rob_head), .flush_in(flush_in),
        .rob_wr_valid(rob_wr_valid), .rob_wr_tag(rob_wr_tag), .rob_wr_value(rob_wr_value),
        .rob_wr_value_en(rob_wr_value_en), .rob_wr_flush(rob_wr_flush), .mt_wr_valid(mt_wr_valid),
        .mt_wr_tag(mt_wr_tag), .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
    );

    always #5 clk = ~clk;

    int nvec = 0, nfail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: one queue of {tag,data} per lane plus a RR pointer.
    logic [TW+DW-1:0] mq [NW][$];
    int rr_m = 0;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) mq[i].delete();
        rr_m = 0;
    endtask

    // Predict from current inputs, clock once, compare, advance the model.
    task automatic cycle();
        logic [NW-1:0] acc, rdy, popm, byp, n_rv, n_ve, n_fl, n_mt, byp_ok;
        logic [NW*TW-1:0] n_rt, n_mtt, m_rt, m_mtt;
        logic [NW*DW-1:0] n_val, m_val;
        logic n_mp; logic [TW-1:0] n_mpt, bd, d, t;
        logic [NC-1:0] n_cv; logic [NC*TW-1:0] n_ct; logic [NC*DW-1:0] n_cval;
        logic [TW+DW-1:0] ent;
        int ng, idx, rr_next;
        acc = '0; popm = '0; byp = '0; n_rv = '0; n_ve = '0; n_fl = '0; n_mt = '0; byp_ok = '0;
        n_rt = '0; n_mtt = '0; n_val = '0; n_mp = 0; n_mpt = '0; bd = '0;
        n_cv = '0; n_ct = '0; n_cval = '0; ng = 0; rr_next = rr_m;
        for (int i = 0; i < NW; i++) rdy[i] = (mq[i].size() < DEPTH);
        chk("wb_ready", {124'd0, wb_ready}, {124'd0, rdy});
        for (int i = 0; i < NW; i++) begin
            t = wb_tag[i*TW +: TW];
            acc[i] = wb_valid[i] && t != 0 && rdy[i] && !flush_in;
            if (acc[i]) begin
                n_rv[i] = 1; n_rt[i*TW +: TW] = t; n_val[i*DW +: DW] = wb_data[i*DW +: DW];
                n_ve[i] = wb_regwr[i] && !wb_cjump[i];
                n_fl[i] = wb_cjump[i] && (wb_pred[i] != wb_taken[i]);
                n_mt[i] = wb_regwr[i] && wb_rd_nz[i]; n_mtt[i*TW +: TW] = t;
                if (n_fl[i]) begin
                    d = t - rob_head;
                    if (!n_mp || d < bd) begin n_mp = 1; bd = d; n_mpt = t; end
                end
            end
`ifdef WB_CDB_BYPASS_EN
            byp_ok[i] = acc[i] && wb_regwr[i] && mq[i].size() == 0;
`endif
        end
        if (!flush_in) begin
            for (int k = 0; k < NW; k++) begin
                idx = (rr_m + k) % NW;
                if ((mq[idx].size() > 0 || byp_ok[idx]) && ng < NC) begin
                    if (mq[idx].size() > 0) begin ent = mq[idx][0]; popm[idx] = 1; end
                    else begin ent = {wb_tag[idx*TW +: TW], wb_data[idx*DW +: DW]}; byp[idx] = 1; end
                    n_cv[ng] = 1; n_ct[ng*TW +: TW] = ent[TW+DW-1 -: TW]; n_cval[ng*DW +: DW] = ent[DW-1:0];
                    ng++; rr_next = (idx + 1) % NW;
                end
            end
        end
        @(posedge clk); #1;
        if (flush_in) model_reset();
        else begin
            for (int i = 0; i < NW; i++) begin
                if (popm[i]) void'(mq[i].pop_front());
                if (acc[i] && wb_regwr[i] && !byp[i]) mq[i].push_back({wb_tag[i*TW +: TW], wb_data[i*DW +: DW]});
            end
            rr_m = rr_next;
        end
        for (int i = 0; i < NW; i++) begin
            m_rt[i*TW +: TW]  = n_rv[i] ? rob_wr_tag[i*TW +: TW] : '0;
            m_mtt[i*TW +: TW] = n_mt[i] ? mt_wr_tag[i*TW +: TW] : '0;
            m_val[i*DW +: DW] = n_rv[i] ? rob_wr_value[i*DW +: DW] : '0;
            if (!n_mt[i]) n_mtt[i*TW +: TW] = '0;
        end
        chk("rob_wr_valid", {124'd0, rob_wr_valid}, {124'd0, n_rv});
        chk("rob_wr_tag", {104'd0, m_rt}, {104'd0, n_rt});
        chk("rob_wr_value", m_val, n_val);
        chk("rob_wr_value_en", {124'd0, rob_wr_value_en}, {124'd0, n_ve});
        chk("rob_wr_flush", {124'd0, rob_wr_flush}, {124'd0, n_fl});
        chk("mt_wr_valid", {124'd0, mt_wr_valid}, {124'd0, n_mt});
        chk("mt_wr_tag", {104'd0, m_mtt}, {104'd0, n_mtt});
        chk("mispredict", {121'd0, mispredict_valid, n_mp ? mispredict_tag : 6'd0}, {121'd0, n_mp, n_mpt});
        chk("cdb_valid", {126'd0, cdb_valid}, {126'd0, n_cv});
        chk("cdb_tag", {116'd0, cdb_tag}, {116'd0, n_ct});
        chk("cdb_value", {64'd0, cdb_value}, {64'd0, n_cval});
    endtask

    task automatic idle();
        wb_valid = '0; wb_regwr = '0; wb_rd_nz = '0; wb_cjump = '0; wb_pred = '0; wb_taken = '0;
        wb_tag = '0; flush_in = 0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_valids"}, {119'd0, rob_wr_valid, mt_wr_valid, mispredict_valid},  '0);
        chk({nm, "_cdb"}, {126'd0, cdb_valid}, '0);
    endtask

    typedef struct {
        logic [NW-1:0] v, rw, rnz, cj, pr, tk;
        logic [NW*TW-1:0] tags;
        logic [TW-1:0] head;
        logic flush;
        logic [NW-1:0] e_rob, e_mt, e_fl;
        logic e_mp; logic [TW-1:0] e_mpt;
        logic [NC-1:0] e_cv; logic [NC*TW-1:0] e_ct;
    } row_t;
    row_t tbl [10];

    task automatic set_row(input int r, input logic [NW-1:0] v, rw, rnz, cj, pr, tk,
                           input logic [NW*TW-1:0] tags, input logic [TW-1:0] head, input logic fl,
                           input logic [NW-1:0] e_rob, e_mt, e_fl, input logic e_mp,
                           input logic [TW-1:0] e_mpt, input logic [NC-1:0] e_cv, input logic [NC*TW-1:0] e_ct);
        tbl[r].v = v; tbl[r].rw = rw; tbl[r].rnz = rnz; tbl[r].cj = cj; tbl[r].pr = pr; tbl[r].tk = tk;
        tbl[r].tags = tags; tbl[r].head = head; tbl[r].flush = fl;
        tbl[r].e_rob = e_rob; tbl[r].e_mt = e_mt; tbl[r].e_fl = e_fl; tbl[r].e_mp = e_mp;
        tbl[r].e_mpt = e_mpt; tbl[r].e_cv = e_cv; tbl[r].e_ct = e_ct;
    endtask

    logic [TW-1:0] obs [$];
    logic saw_full, rdy0;
    int k0, ctr;

    initial begin
        // Rows: inputs of a cycle, outputs expected right after its edge.
        set_row(0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, {6'd0, 6'd0, 6'd0, 6'd5}, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 2'b00, 0);
        set_row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, {6'd0, 6'd5});
        set_row(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        set_row(3, 4'b1111, 4'b1111, 4'b1111, 0, 0, 0, {6'd4, 6'd3, 6'd2, 6'd1}, 0, 0, 4'b1111, 4'b1111, 0, 0, 0, 2'b00, 0);
        set_row(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, {6'd2, 6'd1});
        set_row(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, {6'd4, 6'd3});
        set_row(6, 4'b1010, 0, 0, 4'b1010, 4'b0000, 4'b1010, {6'd3, 6'd0, 6'd9, 6'd0}, 6'd8, 0, 4'b1010, 0, 4'b1010, 1, 6'd9, 2'b00, 0);
        set_row(7, 0, 0, 0, 0, 0, 0, 0, 6'd8, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        set_row(8, 4'b1111, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        set_row(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < NW; i++) wb_data[i*DW +: DW] = 32'hDEADBEEF ^ (32'(i) << 8);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_ready", {124'd0, wb_ready}, {124'd0, 4'b1111});
        chk("reset_tags", {92'd0, cdb_tag, mispredict_tag, rob_wr_tag}, '0);
        @(negedge clk); reset = 1;
        model_reset();

        // Directed table.
        for (int r = 0; r < 10; r++) begin
            wb_valid = tbl[r].v; wb_regwr = tbl[r].rw; wb_rd_nz = tbl[r].rnz; wb_cjump = tbl[r].cj;
            wb_pred = tbl[r].pr; wb_taken = tbl[r].tk; wb_tag = tbl[r].tags; rob_head = tbl[r].head;
            flush_in = tbl[r].flush;
            cycle();
            chk($sformatf("tbl%0d_rob", r), {116'd0, rob_wr_valid, mt_wr_valid, rob_wr_flush}, {116'd0, tbl[r].e_rob, tbl[r].e_mt, tbl[r].e_fl});
            chk($sformatf("tbl%0d_mp", r), {121'd0, mispredict_valid, mispredict_valid ? mispredict_tag : 6'd0},
                {121'd0, tbl[r].e_mp, tbl[r].e_mpt});
`ifndef WB_CDB_BYPASS_EN
            chk($sformatf("tbl%0d_cdb", r), {114'd0, cdb_valid, cdb_tag}, {114'd0, tbl[r].e_cv, tbl[r].e_ct});
`endif
        end
        chk("tbl_value", {96'd0, cdb_value[31:0]}, {96'd0, 32'd0});
        idle();

        // Backpressure: lane 0 holds each result until accepted while the
        // other lanes keep the CDB saturated.
        k0 = 0; ctr = 0; saw_full = 0; obs.delete();
        for (int c = 0; c < 80 && k0 < 12; c++) begin
            wb_valid = 4'b1111; wb_regwr = 4'b1111; wb_rd_nz = 4'b1111;
            wb_tag[5:0] = 6'(40 + k0);
            wb_data[31:0] = 32'h0A000000 + 32'(k0);
            for (int i = 1; i < NW; i++) begin
                wb_tag[i*TW +: TW] = 6'(1 + (ctr % 30)); ctr++;
                wb_data[i*DW +: DW] = $urandom;
            end
            rdy0 = wb_ready[0];
            if (!rdy0) saw_full = 1;
            cycle();
            if (rdy0) k0++;
            for (int p = 0; p < NC; p++)
                if (cdb_valid[p] && cdb_tag[p*TW +: TW] >= 40 && cdb_tag[p*TW +: TW] <= 51) obs.push_back(cdb_tag[p*TW +: TW]);
        end
        idle();
        for (int c = 0; c < 24; c++) begin
            cycle();
            for (int p = 0; p < NC; p++)
                if (cdb_valid[p] && cdb_tag[p*TW +: TW] >= 40 && cdb_tag[p*TW +: TW] <= 51) obs.push_back(cdb_tag[p*TW +: TW]);
        end
        chk("bp_saw_full", {127'd0, saw_full}, {127'd0, 1'b1});
        chk("bp_count", 128'(obs.size()), 128'd12);
        for (int j = 0; j < obs.size() && j < 12; j++) chk($sformatf("bp_order%0d", j), {122'd0, obs[j]}, 128'(40 + j));

        // Flush with three pending entries and new results on every lane.
        wb_valid = 4'b0111; wb_regwr = 4'b0111; wb_tag = {6'd0, 6'd12, 6'd11, 6'd10};
        cycle();
        wb_valid = 4'b1111; wb_regwr = 4'b1111; wb_tag = {6'd16, 6'd15, 6'd14, 6'd13}; flush_in = 1;
        cycle();
        idle();
        chk_quiet("flush");
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk($sformatf("flush_after%0d", c), {126'd0, cdb_valid}, '0);
        end
        chk("flush_ready", {124'd0, wb_ready}, {124'd0, 4'b1111});

        // Async reset between edges in the middle of a burst.
        wb_valid = 4'b1111; wb_regwr = 4'b1111; wb_rd_nz = 4'b1111; wb_tag = {6'd24, 6'd23, 6'd22, 6'd21};
        cycle();
        wb_tag = {6'd28, 6'd27, 6'd26, 6'd25};
        @(posedge clk); #3;
        reset = 0; #1;
        chk_quiet("async_reset");
        chk("async_reset_ready", {124'd0, wb_ready}, {124'd0, 4'b1111});
        model_reset();
        idle();
        @(negedge clk); reset = 1;
        #1 chk("post_reset_ready", {124'd0, wb_ready}, {124'd0, 4'b1111});
        wb_valid = 4'b1111; wb_regwr = 4'b1111; wb_tag = '0;
        cycle();
        chk_quiet("tag0");
        idle();
        cycle();
        chk_quiet("tag0_next");

        // Randomised traffic against the model.
        ctr = 0;
        for (int c = 0; c < 400; c++) begin
            wb_valid = 4'($urandom); wb_regwr = 4'($urandom); wb_rd_nz = 4'($urandom);
            wb_cjump = 4'($urandom); wb_pred = 4'($urandom); wb_taken = 4'($urandom);
            for (int i = 0; i < NW; i++) begin
                // Distinct nonzero tags within a cycle; an occasional tag 0.
                wb_tag[i*TW +: TW] = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'(((ctr + i) % 63) + 1);
                wb_data[i*DW +: DW] = $urandom;
            end
            ctr = ctr + NW;
            rob_head = 6'($urandom);
            flush_in = ($urandom_range(0, 29) == 0);
            cycle();
        end
        idle();
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/wb_commit_multi.md
Name: wb_commit_multi

Overview:
- Parametrised multi-lane writeback/complete stage. Sits between the N_WB execute/memory result lanes and the ROB, map table and common data bus (CDB).
- Per lane it marks the ROB entry ready, records the result value, updates the map table and flags branch mispredictions.
- Results are broadcast on N_CDB CDB ports. Per-lane FIFOs absorb cycles where N_WB > N_CDB, with round-robin arbitration.

Parameters:
N_WB, 4, number of writeback lanes
N_CDB, 2, number of CDB broadcast ports (1..N_WB)
BUF_DEPTH, 4, per-lane pending-broadcast FIFO depth (power of 2, >=2)
DATA_W, 32, result width
TAG_W, 6, ROB tag width; tag 0 = invalid

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wb_valid  in  N_WB  lane result valid
wb_tag  in  N_WB*TAG_W  ROB tag per lane
wb_data  in  N_WB*DATA_W  result per lane
wb_regwr  in  N_WB  instruction writes a register
wb_rd_nz  in  N_WB  destination register is nonzero
wb_cjump  in  N_WB  control-transfer instruction
wb_pred  in  N_WB  predicted taken
wb_taken  in  N_WB  resolved taken
wb_ready  out  N_WB  lane FIFO can accept (count < BUF_DEPTH)
rob_head  in  TAG_W  oldest ROB tag, used for age compare
flush_in  in  1  pipeline flush
rob_wr_valid  out  N_WB  ROB update strobe
rob_wr_tag  out  N_WB*TAG_W  ROB index
rob_wr_value  out  N_WB*DATA_W  value to store
rob_wr_value_en  out  N_WB  value field written (regwr & !cjump)
rob_wr_flush  out  N_WB  set entry's flush bit
mt_wr_valid  out  N_WB  map-table update (regwr & rd_nz)
mt_wr_tag  out  N_WB*TAG_W  tag for map table; in_rob implied 1
mispredict_valid  out  1  one-cycle pulse
mispredict_tag  out  TAG_W  oldest mispredicting tag
cdb_valid  out  N_CDB  broadcast valid
cdb_tag  out  N_CDB*TAG_W  broadcast tag
cdb_value  out  N_CDB*DATA_W  broadcast value

Behaviour:
- Reset (async, reset=0): all outputs 0, except wb_ready all 1. FIFOs are empty and the RR pointer is 0. Reset mid-operation discards all pending broadcasts.
- Lane accepted when wb_valid & wb_tag!=0 & wb_ready & !flush_in. Non-accepted lanes are ignored entirely. The producer must hold the result while wb_ready=0.
- ROB/map-table outputs are registered with 1-cycle latency: accept in cycle N, strobes high in N+1 for one cycle.
  - rob_wr_flush = cjump & (pred ^ taken).
- Mispredict: among lanes flagged in cycle N, select the one with the smallest (tag - rob_head) mod 2^TAG_W.
  - Pulse mispredict_valid with that tag in N+1.
  - Ties are impossible (distinct tags).
- CDB enqueue: accepted lanes with regwr=1 are pushed into that lane's FIFO (cjump+regwr is included; the link value is broadcast).
- Arbitration each cycle: eligible = nonempty FIFO heads.
  - Grant up to N_CDB lanes, scanning from the RR pointer upward with wrap.
  - Granted heads pop; the CDB registers load them and are visible next cycle.
  - Unused CDB ports drive valid=0, tag=0, value=0.
  - RR pointer moves to (last granted lane + 1) mod N_WB; unchanged if no grant.
- Baseline latency: enqueue in N, head arbitrates in N+1, cdb_valid in N+2.
- Full: count==BUF_DEPTH gives wb_ready=0, computed from the registered count; a same-cycle pop does not raise it.
- A simultaneous push and pop on the same lane keeps count unchanged.
- flush_in=1:
  - Same-cycle lanes are not accepted.
  - All FIFOs clear and the RR pointer resets to 0.
  - Next cycle: cdb_valid=0, rob_wr_valid=0, mt_wr_valid=0, mispredict_valid=0.

Optional Feature:
WB_CDB_BYPASS_EN
- Defined: an accepted regwr lane whose FIFO is empty is also eligible in the same cycle. If granted, it goes straight to the CDB register (not enqueued) and appears at N+1. If not granted, it is enqueued normally.
- Undefined: no bypass; the minimum CDB latency is 2 cycles.

Decomposition:
- Shared package (wb_pkg): constants N_WB_DEF, N_CDB_DEF, TAG_W, DATA_W; typedef wb_lane_t {valid, tag, data, regwr, rd_nz, cjump, pred, taken}; typedef cdb_port_t {valid, tag, value}. TAG_W and DATA_W reuse the existing RobSize/MemoryWord widths.
- One sub-module, wb_lane_fifo: parametrised DATA_W+TAG_W wide, BUF_DEPTH deep, with push, pop, count, head; instantiated N_WB times.

Test Plan:
1. Single lane 0, tag 5, data 0xDEADBEEF, regwr, rd_nz:
   - rob_wr_valid[0], tag 5, value_en=1 and mt_wr_valid at N+1.
   - cdb_valid[0], tag 5, value 0xDEADBEEF at N+2 (N+1 with bypass).
2. All 4 lanes, regwr, tags 1-4, same cycle, N_CDB=2:
   - Tags 1,2 broadcast at N+2; tags 3,4 at N+3.
   - RR pointer ends at 0.
3. Lanes 1 and 3 mispredict with tags 9 and 3, rob_head=8:
   - mispredict_tag=9 (distance 1 < 59).
   - rob_wr_flush set on both lanes.
4. Lane 0 driven with BUF_DEPTH+1 back-to-back results while the other lanes saturate the CDB:
   - wb_ready[0]=0 after 4 pushes.
   - The held 5th result is accepted only after a pop; no loss or duplication; order is preserved.
5. flush_in with 3 pending entries plus new wb_valid on all lanes:
   - Next cycle all valid outputs are 0, FIFOs are empty, and no later broadcast of the flushed tags occurs.
6. Async reset asserted mid-burst, between clock edges:
   - Outputs go 0 immediately; wb_ready=1 after reset release.
   - Tag 0 with wb_valid=1 produces no outputs.
